xnor_popcount_pe: RTL and testbench

Parametrised multi-lane successor of the single-bit systolic PE in the BCNN popcount array.
- Each accepted beat XNORs LANES activation bits against a stationary weight register, masks unused lanes, popcounts the result and accumulates over a multi-beat window (in_first..in_last).
- At window end it presents a saturated sum plus a binarised activation (sum >= threshold) behind a valid/ready handshake.
- Accepted activations are forwarded one cycle later to the next PE in the row.

---
 rtl/bcnn_pkg.sv | 28 ++
 rtl/popcount_tree.sv | 35 +++
 rtl/xnor_popcount_pe.sv | 106 ++++++++++
 tb/tb_xnor_popcount_pe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcnn_pkg.sv
// Shared types and helpers for the BCNN popcount array.
// Holds the PE state encoding and the saturating adder.
package bcnn_pkg;

  localparam int LANES_DEF     = 8;
  localparam int SUM_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } pe_state_t;

  // bit 32 flags a clamp; low w bits hold the clamped sum
  function automatic logic [32:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    if (s > mx) return {1'b1, mx[31:0]};
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Balanced combinational popcount built by recursive halving.
// Output is wide enough to hold N.
module popcount_tree #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  if (N == 1) begin : g_leaf
    assign count = CW'(bits);
  end else begin : g_node
    localparam int NL = N / 2;
    localparam int NH = N - NL;
    localparam int CL = $clog2(NL + 1);
    localparam int CH = $clog2(NH + 1);

    logic [CL-1:0] cl;
    logic [CH-1:0] ch;

    popcount_tree #(.N(NL)) u_lo (
      .bits  (bits[NL-1:0]),
      .count (cl)
    );

    popcount_tree #(.N(NH)) u_hi (
      .bits  (bits[N-1:NL]),
      .count (ch)
    );

    assign count = CW'(cl) + CW'(ch);
  end

endmodule

// File: rtl/xnor_popcount_pe.sv
// Multi-lane XNOR-popcount PE with windowed saturating accumulation,
// binarised result behind valid/ready, and activation forwarding.
module xnor_popcount_pe
  import bcnn_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 weight_load,
  input  logic [LANES-1:0]     weight_bits,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES-1:0]     in_bits,
  input  logic [LANES-1:0]     in_mask,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [SUM_WIDTH-1:0] partial_sum_in,
  input  logic [SUM_WIDTH-1:0] threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_WIDTH-1:0] out_sum,
  output logic                 out_bit,
  output logic                 out_sat,
  output logic                 fwd_valid,
  output logic [LANES-1:0]     fwd_bits
);

  localparam int CW = $clog2(LANES + 1);

  pe_state_t            state;
  logic [LANES-1:0]     weights;
  logic [SUM_WIDTH-1:0] acc;
  logic                 sat;

  logic [LANES-1:0]     xn;
  logic [CW-1:0]        pc;
  logic                 accept;
  logic                 first_eff;
  logic                 ld_ok;
  logic [SUM_WIDTH-1:0] base;
  logic [32:0]          add_r;
  logic [SUM_WIDTH-1:0] sum_n;
  logic                 sat_n;
  logic                 bit_n;
  logic                 unused_hi;

  assign xn = ~(in_bits ^ weights) & in_mask;

  popcount_tree #(.N(LANES)) u_pc (
    .bits  (xn),
    .count (pc)
  );

  // gated so the PE reports not-ready while held in reset
  assign in_ready  = reset_n & ((state != S_HOLD) | out_ready);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid & in_ready;
  assign first_eff = (state != S_ACC) | in_first;
  assign base      = first_eff ? partial_sum_in : acc;
  assign add_r     = sat_add(32'(base), 32'(pc), SUM_WIDTH);
  assign sum_n     = add_r[SUM_WIDTH-1:0];
  assign sat_n     = add_r[32] | (~first_eff & sat);
  assign bit_n     = (sum_n >= threshold);
  assign unused_hi = ^add_r[31:SUM_WIDTH];

  assign ld_ok = weight_load &
                 ((state == S_IDLE) |
                  ((state == S_HOLD) & ~accept));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      weights   <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_bit   <= 1'b0;
      out_sat   <= 1'b0;
      fwd_valid <= 1'b0;
      fwd_bits  <= '0;
    end else begin
      if (ld_ok) weights <= weight_bits;
      fwd_valid <= accept;
      if (accept) begin
        fwd_bits <= in_bits;
        acc      <= sum_n;
        sat      <= sat_n;
      end
      unique case (1'b1)
        accept & in_last: begin
          state   <= S_HOLD;
          out_sum <= sum_n;
          out_bit <= bit_n;
          out_sat <= sat_n;
        end
        accept & ~in_last: state <= S_ACC;
        ~accept & (state == S_HOLD) & out_ready:
          state <= S_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_popcount_pe.sv
// Randomised scoreboard bench for xnor_popcount_pe.
// Window-level reference model; monitor pops on each result handshake.
module tb_xnor_popcount_pe;

  localparam int L    = 8;
  localparam int SW   = 8;
  localparam int MAXS = 255;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          weight_load;
  logic [L-1:0]  weight_bits;
  logic          in_valid;
  logic          in_ready;
  logic [L-1:0]  in_bits;
  logic [L-1:0]  in_mask;
  logic          in_first;
  logic          in_last;
  logic [SW-1:0] partial_sum_in;
  logic [SW-1:0] threshold;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          out_bit;
  logic          out_sat;
  logic          fwd_valid;
  logic [L-1:0]  fwd_bits;

  xnor_popcount_pe #(.LANES(L), .SUM_WIDTH(SW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .weight_load    (weight_load),
    .weight_bits    (weight_bits),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_bits        (in_bits),
    .in_mask        (in_mask),
    .in_first       (in_first),
    .in_last        (in_last),
    .partial_sum_in (partial_sum_in),
    .threshold      (threshold),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_bit        (out_bit),
    .out_sat        (out_sat),
    .fwd_valid      (fwd_valid),
    .fwd_bits       (fwd_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    bit b;
    bit sat;
  } res_t;

  res_t       sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;

  logic [L-1:0] m_w;
  bit           m_win;
  bit           m_hold;
  int           m_acc;
  bit           m_sat;
  bit           ef_v;
  logic [L-1:0] ef_b;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = '0; m_win = 0; m_hold = 0;
    m_acc = 0; m_sat = 0; ef_v = 0; ef_b = '0;
    sbq.delete();
  endtask

  task automatic cyc();
    bit exp_rdy, acc, first, ov, ld;
    int s, base;
    #1;
    exp_rdy = !m_hold || out_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("fwd_valid", 32'(fwd_valid), 32'(ef_v));
    if (ef_v) chk("fwd_bits", 32'(fwd_bits), 32'(ef_b));
    acc = in_valid && exp_rdy;
    @(posedge clk);
    ld = weight_load &&
         ((!m_hold && !m_win) || (m_hold && !acc));
    ef_v = acc;
    if (acc) begin
      ef_b  = in_bits;
      first = !m_win || in_first;
      base  = first ? int'(partial_sum_in) : m_acc;
      s     = base + $countones(~(in_bits ^ m_w) & in_mask);
      ov    = s > MAXS;
      if (ov) s = MAXS;
      m_sat = first ? ov : (m_sat || ov);
      if (in_last) begin
        sbq.push_back('{s, s >= int'(threshold), m_sat});
        m_win  = 0;
        m_hold = 1;
      end else begin
        m_win  = 1;
        m_hold = 0;
        m_acc  = s;
      end
    end else if (m_hold && out_ready) begin
      m_hold = 0;
    end
    if (ld) m_w = weight_bits;
    @(negedge clk);
  endtask

  task automatic beat(input logic [L-1:0] b, input logic [L-1:0] m,
                      input bit f, input bit l,
                      input int ps, input int th);
    in_valid = 1; in_bits = b; in_mask = m;
    in_first = f; in_last = l;
    partial_sum_in = SW'(ps); threshold = SW'(th);
    cyc();
  endtask

  task automatic idle();
    in_valid = 0;
    cyc();
  endtask

  task automatic load_w(input logic [L-1:0] w);
    in_valid = 0; weight_load = 1; weight_bits = w;
    cyc();
    weight_load = 0;
  endtask

  task automatic chk_out(input int s, input bit b, input bit sa);
    chk("dir_valid", 32'(out_valid), 32'd1);
    chk("dir_sum", 32'(out_sum), 32'(s));
    chk("dir_bit", 32'(out_bit), 32'(b));
    chk("dir_sat", 32'(out_sat), 32'(sa));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_out_sum"}, 32'(out_sum), 32'd0);
    chk({nm, "_out_bit"}, 32'(out_bit), 32'd0);
    chk({nm, "_out_sat"}, 32'(out_sat), 32'd0);
    chk({nm, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({nm, "_fwd_bits"}, 32'(fwd_bits), 32'd0);
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    model_reset();
    #1 chk_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset_n) begin
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        if (out_valid) begin
          if (sbq.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
          end else begin
            e = sbq[0];
            chk("sb_sum", 32'(out_sum), 32'(e.s));
            chk("sb_bit", 32'(out_bit), 32'(e.b));
            chk("sb_sat", 32'(out_sat), 32'(e.sat));
            if (out_ready) void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_n = 0; weight_load = 0; weight_bits = '0;
    in_valid = 0; in_bits = '0; in_mask = '0;
    in_first = 0; in_last = 0; out_ready = 1;
    partial_sum_in = '0; threshold = '0;
    model_reset();
    #3 chk_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;

    load_w(8'hF0);
    beat(8'hF0, 8'hFF, 1, 1, 3, 10);
    chk_out(11, 1, 0);
    idle();

    load_w(8'hA5);
    beat(8'hA5, 8'hFF, 1, 0, 0, 11);
    beat(8'h00, 8'h0F, 0, 1, 0, 11);
    chk_out(10, 0, 0);
    idle();

    load_w(8'hFF);
    beat(8'hFF, 8'hFF, 1, 1, 250, 0);
    chk_out(255, 1, 1);
    beat(8'h00, 8'hFF, 1, 1, 0, 1);
    chk_out(0, 0, 0);
    idle();

    out_ready = 0;
    beat(8'h0F, 8'h33, 1, 1, 7, 9);
    in_bits = 8'h5A;
    repeat (3) cyc();
    out_ready = 1;
    cyc();
    idle();

    load_w(8'h0F);
    beat(8'h0F, 8'hFF, 1, 0, 40, 0);
    weight_load = 1; weight_bits = 8'hFF;
    beat(8'h0F, 8'hFF, 1, 0, 1, 0);
    weight_load = 0;
    beat(8'h0F, 8'hFF, 0, 1, 0, 20);
    chk_out(17, 0, 0);
    idle();

    beat(8'h0F, 8'hFF, 1, 0, 2, 0);
    in_valid = 0;
    do_reset();
    beat(8'hF0, 8'hFF, 1, 1, 5, 9);
    chk_out(9, 1, 0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      in_valid       = ($urandom % 4) != 0;
      in_bits        = L'($urandom);
      in_mask        = ($urandom % 3 == 0) ? 8'hFF : L'($urandom);
      in_first       = ($urandom % 4) == 0;
      in_last        = ($urandom % 3) == 0;
      partial_sum_in = ($urandom % 8 == 0) ?
                       SW'($urandom_range(200, 255)) :
                       SW'($urandom_range(0, 20));
      threshold      = SW'($urandom_range(0, 60));
      out_ready      = ($urandom % 4) != 0;
      weight_load    = ($urandom % 8) == 0;
      weight_bits    = L'($urandom);
      cyc();
    end

    in_valid = 0; weight_load = 0; out_ready = 1;
    repeat (4) cyc();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
